systolic_mm_engine: RTL and testbench

- Self-contained output-stationary ROWS x COLS signed matrix-multiply engine: C[ROWS][COLS] = A[ROWS][K] x B[K][COLS], K chosen per job at runtime.
- Adds what the bare PE grid lacks: input skew registers, a job FSM with valid/ready streaming, array stall, pipeline drain and row-serial result readout.
- Sits between the operand buffers (producer) and the result writeback (consumer).

---
 rtl/systolic_mm_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary signed ROWS x COLS matrix-multiply engine
// Skewed operand feed, stallable array, drain phase and row-serial result readout.
module systolic_mm_engine #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int MAX_K      = 16,
    parameter int KW         = 5,
    parameter int RW         = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_col,
    input  logic [COLS*DATA_WIDTH-1:0] b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RW-1:0]              out_row_idx,
    output logic [COLS*ACC_WIDTH-1:0]  out_data,
    output logic                       done
);

    localparam int DRAIN_LEN = ROWS + COLS - 2;
    localparam int DCW       = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [KW-1:0]  MAX_K_V    = KW'(MAX_K);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_OUTPUT} state_t;

    state_t         state, state_nxt;
    logic [KW-1:0]  k_lat, beat_cnt, k_eff;
    logic [DCW-1:0] drain_cnt;
    logic [RW-1:0]  row_cnt;
    logic           beat, advance, clear, last_beat, drain_last, row_last;

    logic signed [DATA_WIDTH-1:0] a_src  [ROWS];
    logic signed [DATA_WIDTH-1:0] b_src  [COLS];
    logic signed [DATA_WIDTH-1:0] a_edge [ROWS];
    logic signed [DATA_WIDTH-1:0] b_edge [COLS];
    logic signed [DATA_WIDTH-1:0] a_fwd  [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_fwd  [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_w  [ROWS][COLS];

    assign k_eff      = (k_len > MAX_K_V) ? MAX_K_V : k_len;
    assign beat       = (state == S_STREAM) && in_valid;
    assign advance    = beat || (state == S_DRAIN);
    assign clear      = (state == S_IDLE) && start;
    assign last_beat  = beat && (beat_cnt == k_lat - KW'(1));
    assign drain_last = (drain_cnt == DRAIN_LAST);
    assign row_last   = (row_cnt == ROW_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        in_ready  = (state == S_STREAM);
        out_valid = (state == S_OUTPUT);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (k_eff == '0) ? S_OUTPUT : S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_beat) begin
                    state_nxt = (DRAIN_LEN == 0) ? S_OUTPUT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready && row_last) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            if (clear) begin
                k_lat     <= k_eff;
                beat_cnt  <= '0;
                drain_cnt <= '0;
                row_cnt   <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DCW'(1);
            end
            if ((state == S_OUTPUT) && out_ready) begin
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end
        end
    end

    // Zeros are injected once streaming ends so the drain flushes real data only.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_src[i] = (state == S_STREAM) ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            b_src[j] = (state == S_STREAM) ? b_row[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_pass
            assign a_edge[gi] = a_src[gi];
        end else begin : g_sr
            logic signed [DATA_WIDTH-1:0] sr [gi];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int n = 0; n < gi; n++) sr[n] <= '0;
                end else if (clear) begin
                    for (int n = 0; n < gi; n++) sr[n] <= '0;
                end else if (advance) begin
                    sr[0] <= a_src[gi];
                    for (int n = 1; n < gi; n++) sr[n] <= sr[n-1];
                end
            end
            assign a_edge[gi] = sr[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_pass
            assign b_edge[gj] = b_src[gj];
        end else begin : g_sr
            logic signed [DATA_WIDTH-1:0] sr [gj];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int n = 0; n < gj; n++) sr[n] <= '0;
                end else if (clear) begin
                    for (int n = 0; n < gj; n++) sr[n] <= '0;
                end else if (advance) begin
                    sr[0] <= b_src[gj];
                    for (int n = 1; n < gj; n++) sr[n] <= sr[n-1];
                end
            end
            assign b_edge[gj] = sr[gj-1];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
            logic signed [DATA_WIDTH-1:0]   a_in, b_in, a_q, b_q;
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic signed [ACC_WIDTH-1:0]    acc_q;

            if (gj == 0) begin : g_aedge
                assign a_in = a_edge[gi];
            end else begin : g_ainner
                assign a_in = a_fwd[gi][gj-1];
            end
            if (gi == 0) begin : g_bedge
                assign b_in = b_edge[gj];
            end else begin : g_binner
                assign b_in = b_fwd[gi-1][gj];
            end

            assign prod = a_in * b_in;

            // Sign-extended product; accumulation wraps modulo 2^ACC_WIDTH.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (clear) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (advance) begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= acc_q + ACC_WIDTH'(prod);
                end
            end

            assign a_fwd[gi][gj] = a_q;
            assign b_fwd[gi][gj] = b_q;
            assign acc_w[gi][gj] = acc_q;
        end
    end

    assign out_row_idx = row_cnt;

    always_comb begin
        out_data = '0;
        if (state == S_OUTPUT) begin
            for (int j = 0; j < COLS; j++) begin
                out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_cnt][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - directed self-checking bench for systolic_mm_engine
module tb_systolic_mm_engine;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int KW   = 5;
    localparam int RW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   a_col;
    logic [COLS*DW-1:0]   b_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [RW-1:0]        out_row_idx;
    logic [COLS*AW-1:0]   out_data;
    logic                 done;

    always #5 clk = ~clk;

    systolic_mm_engine #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
        .MAX_K(16), .KW(KW), .RW(RW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
        .out_data(out_data), .done(done)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     am [ROWS][16];
    int     bm [16][COLS];
    longint ex [ROWS][COLS];
    bit     vpat [7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint elem(input int j);
        logic [AW-1:0] raw;
        raw = out_data[j*AW +: AW];
        return longint'($signed(raw));
    endfunction

    task automatic set_operands(input int bi);
        for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = (bi < 16) ? am[i][bi][DW-1:0] : '0;
        for (int j = 0; j < COLS; j++) b_row[j*DW +: DW] = (bi < 16) ? bm[bi][j][DW-1:0] : '0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 16; k++) am[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < COLS; j++) bm[k][j] = (k < 4) ? 4*k + j + 1 : 0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) ex[i][j] = 4*i + j + 1;
    endtask

    task automatic load_const(input int av, input int bv, input longint cv);
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 16; k++) am[i][k] = av;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < COLS; j++) bm[k][j] = bv;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) ex[i][j] = cv;
    endtask

    // Cycle n counts rising edges after the edge that samples start.
    task automatic run_job(input string tag, input int kin, input int keff, input bit pat,
                           input int stall_row, input int stall_cyc);
        int bi, first, done_at, er, stall_left, ir_seen, exp_first;
        bi = 0; first = -1; done_at = -1; er = 0; stall_left = stall_cyc; ir_seen = 0;
        @(negedge clk);
        start = 1'b1; k_len = kin[KW-1:0]; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 1; n <= 200 && done_at < 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            set_operands(bi);
            in_valid = (pat && n <= 7) ? vpat[n-1] : 1'b1;
            if (pat && n <= 7) check({tag, " in_ready"}, in_ready, 1);
            if (in_ready) ir_seen++;
            if (in_ready && in_valid) bi++;
            out_ready = 1'b1;
            if (out_valid && out_row_idx == stall_row && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                check({tag, " hold idx"}, out_row_idx, stall_row);
                for (int j = 0; j < COLS; j++) check({tag, " hold data"}, elem(j), ex[stall_row][j]);
            end
            #1;
            if (out_valid && first < 0) first = n;
            if (out_valid && out_ready) begin
                check({tag, " row idx"}, out_row_idx, er);
                for (int j = 0; j < COLS; j++) check({tag, " data"}, elem(j), ex[er][j]);
                er++;
            end
            if (done) done_at = n;
        end
        exp_first = (keff == 0) ? 1 : keff + (pat ? 3 : 0) + 7;
        check({tag, " first out_valid"}, first, exp_first);
        check({tag, " done cycle"}, done_at, exp_first + 3 + stall_cyc);
        check({tag, " rows"}, er, 4);
        if (keff == 0) check({tag, " in_ready seen"}, ir_seen, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, " busy after done"}, busy, 0);
    endtask

    initial begin
        int ov_seen, dn_seen;
        reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        a_col = '0; b_row = '0;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst done", done, 0);
        check("rst row_idx", out_row_idx, 0);
        check("rst data zero", out_data == '0, 1);
        reset = 1'b1;

        load_identity();
        run_job("ident", 4, 4, 0, -1, 0);
        run_job("stall_in", 4, 4, 1, -1, 0);
        run_job("backpr", 4, 4, 0, 1, 3);

        load_const(127, -128, -260096);
        run_job("clamp", 31, 16, 0, -1, 0);
        load_const(-128, -128, 262144);
        run_job("negneg", 16, 16, 0, -1, 0);

        load_const(0, 0, 0);
        run_job("zero", 0, 0, 0, -1, 0);

        load_identity();
        dn_seen = 0;
        @(negedge clk);
        start = 1'b1; k_len = 5'd4;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            start = 1'b0;
            set_operands(n);
            in_valid = 1'b1;
            if (done) dn_seen++;
        end
        @(negedge clk);
        if (done) dn_seen++;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        ov_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
            if (done) dn_seen++;
        end
        check("abort no output", ov_seen, 0);
        check("abort no done", dn_seen, 0);
        run_job("rerun", 4, 4, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
